// File: rtl/note_pkg.sv
// Shared constants and types for the buzzer note arbiter.
package note_pkg;

    localparam int NOTE_W = 8;
    localparam logic [NOTE_W-1:0] NOTE_REST = '0;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_SONG = 2'b01;
    localparam logic [1:0] OWNER_KEY  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_SONG,
        ST_KEY,
        ST_HOLD
    } arbState_t;

    function automatic int maxInt(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/note_arbiter_gap_timer.sv
// Loadable saturating down counter used for both the articulation gap
// and the post-release holdoff.
module gap_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] loadValue,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/note_arbiter.sv
// Arbitrates the buzzer note path between live key notes and song
// playback, inserting a silent gap before each new note.
module note_arbiter #(
    parameter int GAP_CYCLES     = 4,
    parameter int HOLDOFF_CYCLES = 10,
    parameter int NOTE_W         = 8
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic [NOTE_W-1:0] iKey_Note,
    input  logic [NOTE_W-1:0] iSong_Note,
    input  logic              iSong_Valid,
    output logic [NOTE_W-1:0] oFreq_Data,
    output logic              oCountEnable,
    output logic              oSongHold,
    output logic [1:0]        oOwner
);

    import note_pkg::*;

    localparam int MAXC = maxInt(GAP_CYCLES, HOLDOFF_CYCLES);
    localparam int CW   = $clog2(MAXC + 1);
    localparam bit NO_GAP = (GAP_CYCLES == 0);
    // Counter exits on the edge after it reads zero, hence the minus one.
    localparam logic [CW-1:0] GAP_LOAD =
        CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF_CYCLES - 1);

    arbState_t         state;
    arbState_t         nextState;
    logic [NOTE_W-1:0] note;
    logic [NOTE_W-1:0] nextNote;
    logic              pendKey;
    logic              nextPendKey;
    logic              goGap;
    logic              goHold;
    logic              startNote;
    logic              timerLoad;
    logic [CW-1:0]     timerValue;
    logic              timerDone;
    logic              keyOn;
    logic              keyChg;
    logic              songChg;
    logic [NOTE_W-1:0] nextFreq;
    logic [1:0]        nextOwner;
    logic              nextHold;
    logic              nextPulse;

    assign keyOn   = |iKey_Note;
    assign keyChg  = (iKey_Note != note);
    assign songChg = (iSong_Note != note);

    gap_timer #(
        .W(CW)
    ) uTimer (
        .clk      (iClk),
        .rst      (iReset),
        .load     (timerLoad),
        .loadValue(timerValue),
        .done     (timerDone)
    );

    assign timerLoad  = goGap | goHold;
    assign timerValue = goHold ? HOLD_LOAD : GAP_LOAD;

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state        <= ST_IDLE;
            note         <= '0;
            pendKey      <= 1'b0;
            oFreq_Data   <= '0;
            oCountEnable <= 1'b0;
            oSongHold    <= 1'b0;
            oOwner       <= OWNER_NONE;
        end else begin
            state        <= nextState;
            note         <= nextNote;
            pendKey      <= nextPendKey;
            oFreq_Data   <= nextFreq;
            oCountEnable <= nextPulse;
            oSongHold    <= nextHold;
            oOwner       <= nextOwner;
        end
    end

    always_comb begin
        nextState   = state;
        nextNote    = note;
        nextPendKey = pendKey;
        goGap       = 1'b0;
        goHold      = 1'b0;
        startNote   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (keyOn) begin
                    nextNote    = iKey_Note;
                    nextPendKey = 1'b1;
                    goGap       = 1'b1;
                end else if (iSong_Valid) begin
                    nextNote    = iSong_Note;
                    nextPendKey = 1'b0;
                    goGap       = 1'b1;
                end
            end
            ST_GAP: begin
                if (pendKey) begin
                    if (!keyOn) begin
                        goHold = 1'b1;
                    end else if (keyChg) begin
                        nextNote = iKey_Note;
                        goGap    = 1'b1;
                    end else if (timerDone) begin
                        nextState = ST_KEY;
                        startNote = 1'b1;
                    end
                end else if (keyOn) begin
                    nextNote    = iKey_Note;
                    nextPendKey = 1'b1;
                    goGap       = 1'b1;
                end else if (!iSong_Valid) begin
                    nextState = ST_IDLE;
                end else begin
                    // Song edits track silently without restarting the gap.
                    nextNote = iSong_Note;
                    if (timerDone) begin
                        nextState = ST_SONG;
                        startNote = 1'b1;
                    end
                end
            end
            ST_SONG: begin
                if (keyOn) begin
                    nextNote    = iKey_Note;
                    nextPendKey = 1'b1;
                    goGap       = 1'b1;
                end else if (!iSong_Valid) begin
                    nextState = ST_IDLE;
                end else if (songChg) begin
                    nextNote = iSong_Note;
                    goGap    = 1'b1;
                end
            end
            ST_KEY: begin
                if (!keyOn) begin
                    goHold = 1'b1;
                end else if (keyChg) begin
                    nextNote = iKey_Note;
                    goGap    = 1'b1;
                end
            end
            ST_HOLD: begin
                if (keyOn) begin
                    nextNote    = iKey_Note;
                    nextPendKey = 1'b1;
                    goGap       = 1'b1;
                end else if (timerDone) begin
                    nextPendKey = 1'b0;
                    if (iSong_Valid) begin
                        nextNote = iSong_Note;
                        goGap    = 1'b1;
                    end else begin
                        nextState = ST_IDLE;
                    end
                end
            end
            default: nextState = ST_IDLE;
        endcase
        if (goHold) begin
            nextState   = ST_HOLD;
            nextPendKey = 1'b1;
        end
        if (goGap) begin
            if (NO_GAP) begin
                nextState = nextPendKey ? ST_KEY : ST_SONG;
                startNote = 1'b1;
            end else begin
                nextState = ST_GAP;
            end
        end
    end

    always_comb begin
        nextFreq  = '0;
        nextOwner = OWNER_NONE;
        nextHold  = 1'b0;
        unique case (nextState)
            ST_SONG: begin
                nextFreq  = nextNote;
                nextOwner = OWNER_SONG;
            end
            ST_KEY: begin
                nextFreq  = nextNote;
                nextOwner = OWNER_KEY;
                nextHold  = 1'b1;
            end
            ST_HOLD: begin
                nextOwner = OWNER_KEY;
                nextHold  = 1'b1;
            end
            ST_GAP: begin
                nextOwner = nextPendKey ? OWNER_KEY : OWNER_SONG;
                nextHold  = nextPendKey;
            end
            default: ;
        endcase
    end

    assign nextPulse = startNote & (|nextNote);

endmodule

// File: tb/tb_note_arbiter.sv
// Bench for note_arbiter: a GAP=4 and a GAP=0 instance share stimulus
// and are checked every cycle against a countdown model.
module tb_note_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] key = '0;
    logic [7:0] song = '0;
    logic       valid = 1'b0;

    logic [7:0] freqA, freqB;
    logic       ceA, ceB, holdA, holdB;
    logic [1:0] ownA, ownB;

    int nAsserts = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    note_arbiter #(
        .GAP_CYCLES(4), .HOLDOFF_CYCLES(10), .NOTE_W(8)
    ) dut (
        .iClk(clk), .iReset(rst), .iKey_Note(key), .iSong_Note(song),
        .iSong_Valid(valid), .oFreq_Data(freqA), .oCountEnable(ceA),
        .oSongHold(holdA), .oOwner(ownA)
    );

    note_arbiter #(
        .GAP_CYCLES(0), .HOLDOFF_CYCLES(10), .NOTE_W(8)
    ) dutZ (
        .iClk(clk), .iReset(rst), .iKey_Note(key), .iSong_Note(song),
        .iSong_Valid(valid), .oFreq_Data(freqB), .oCountEnable(ceB),
        .oSongHold(holdB), .oOwner(ownB)
    );

    task automatic chk(string name, int act, int exp);
        nAsserts++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner 0 none / 1 song / 2 key; counts are remaining cycles.
    int         mOwn[2];
    bit         mSnd[2];
    logic [7:0] mNote[2];
    int         mGap[2];
    int         mHold[2];
    bit         mPulse[2];

    function automatic int gapOf(int i);
        return (i == 0) ? 4 : 0;
    endfunction

    function automatic int expFreq(int i);
        return mSnd[i] ? int'(mNote[i]) : 0;
    endfunction

    task automatic mIdle(int i);
        mOwn[i] = 0; mSnd[i] = 0; mGap[i] = 0; mHold[i] = 0;
    endtask

    task automatic mStart(int i, int own, logic [7:0] n);
        mOwn[i] = own; mNote[i] = n; mHold[i] = 0;
        if (gapOf(i) == 0) begin
            mSnd[i] = 1; mGap[i] = 0; mPulse[i] = (n != '0);
        end else begin
            mSnd[i] = 0; mGap[i] = gapOf(i);
        end
    endtask

    task automatic mSound(int i);
        mGap[i] = 0; mSnd[i] = 1; mPulse[i] = (mNote[i] != '0);
    endtask

    task automatic mHoldoff(int i);
        mOwn[i] = 2; mSnd[i] = 0; mGap[i] = 0; mHold[i] = 10;
    endtask

    task automatic mStep(int i);
        mPulse[i] = 0;
        if (mHold[i] > 0) begin
            if (key != '0) mStart(i, 2, key);
            else if (mHold[i] == 1) begin
                if (valid) mStart(i, 1, song);
                else mIdle(i);
            end else mHold[i] = mHold[i] - 1;
        end else if (mGap[i] > 0) begin
            if (mOwn[i] == 2) begin
                if (key == '0) mHoldoff(i);
                else if (key != mNote[i]) mStart(i, 2, key);
                else if (mGap[i] == 1) mSound(i);
                else mGap[i] = mGap[i] - 1;
            end else begin
                if (key != '0) mStart(i, 2, key);
                else if (!valid) mIdle(i);
                else begin
                    mNote[i] = song;
                    if (mGap[i] == 1) mSound(i);
                    else mGap[i] = mGap[i] - 1;
                end
            end
        end else if (mSnd[i]) begin
            if (mOwn[i] == 2) begin
                if (key == '0) mHoldoff(i);
                else if (key != mNote[i]) mStart(i, 2, key);
            end else begin
                if (key != '0) mStart(i, 2, key);
                else if (!valid) mIdle(i);
                else if (song != mNote[i]) mStart(i, 1, song);
            end
        end else begin
            if (key != '0) mStart(i, 2, key);
            else if (valid) mStart(i, 1, song);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            mIdle(i); mNote[i] = '0; mPulse[i] = 0;
        end
        forever begin
            @(posedge clk or posedge rst);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    mIdle(i); mPulse[i] = 0;
                end else begin
                    mStep(i);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("cmpFreqA", int'(freqA), expFreq(0));
            chk("cmpCeA", int'(ceA), int'(mPulse[0]));
            chk("cmpHoldA", int'(holdA), (mOwn[0] == 2) ? 1 : 0);
            chk("cmpOwnA", int'(ownA), mOwn[0]);
            chk("cmpFreqZ", int'(freqB), expFreq(1));
            chk("cmpCeZ", int'(ceB), int'(mPulse[1]));
            chk("cmpHoldZ", int'(holdB), (mOwn[1] == 2) ? 1 : 0);
            chk("cmpOwnZ", int'(ownB), mOwn[1]);
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tick(2);
        chk("rstFreq", int'(freqA), 0);
        chk("rstCe", int'(ceA), 0);
        chk("rstHold", int'(holdA), 0);
        chk("rstOwn", int'(ownA), 0);
        rst = 1'b0;
        tick(1);
        chk("idleOwn", int'(ownA), 0);

        valid = 1'b1; song = 8'd5;
        tick(1);
        chk("songGapOwn", int'(ownA), 1);
        chk("songGapFreq", int'(freqA), 0);
        chk("zSongFreq", int'(freqB), 5);
        chk("zSongCe", int'(ceB), 1);
        tick(3);
        chk("songGapEnd", int'(freqA), 0);
        tick(1);
        chk("songFreq", int'(freqA), 5);
        chk("songCe", int'(ceA), 1);
        chk("songHold", int'(holdA), 0);
        tick(1);
        chk("songCeOnce", int'(ceA), 0);

        key = 8'd12;
        tick(1);
        chk("keyGapOwn", int'(ownA), 2);
        chk("keyGapHold", int'(holdA), 1);
        chk("keyGapFreq", int'(freqA), 0);
        tick(3);
        chk("keyGapEnd", int'(freqA), 0);
        tick(1);
        chk("keyFreq", int'(freqA), 12);
        chk("keyCe", int'(ceA), 1);

        key = 8'd0;
        tick(1);
        chk("holdFreq", int'(freqA), 0);
        chk("holdSh", int'(holdA), 1);
        tick(9);
        chk("holdLastOwn", int'(ownA), 2);
        chk("holdLastSh", int'(holdA), 1);
        tick(1);
        chk("resumeOwn", int'(ownA), 1);
        chk("resumeSh", int'(holdA), 0);
        chk("resumeGap", int'(freqA), 0);
        tick(3);
        chk("resumeGapEnd", int'(freqA), 0);
        tick(1);
        chk("resumeFreq", int'(freqA), 5);
        chk("resumeCe", int'(ceA), 1);

        key = 8'd12;
        tick(5);
        chk("key2Freq", int'(freqA), 12);
        key = 8'd0;
        tick(3);
        key = 8'd7;
        tick(1);
        chk("repressOwn", int'(ownA), 2);
        chk("repressSh", int'(holdA), 1);
        chk("repressGap", int'(freqA), 0);
        tick(3);
        chk("repressGapEnd", int'(freqA), 0);
        tick(1);
        chk("repressFreq", int'(freqA), 7);
        chk("repressCe", int'(ceA), 1);
        tick(15);
        chk("noResumeFreq", int'(freqA), 7);
        chk("noResumeOwn", int'(ownA), 2);

        key = 8'd3;
        tick(2);
        key = 8'd9;
        tick(4);
        chk("reloadSilent", int'(freqA), 0);
        tick(1);
        chk("reloadNote", int'(freqA), 9);

        key = 8'd0;
        tick(11);
        chk("relatchGapOwn", int'(ownA), 1);
        song = 8'd6;
        tick(3);
        chk("relatchSilent", int'(freqA), 0);
        tick(1);
        chk("relatchNote", int'(freqA), 6);
        chk("relatchCe", int'(ceA), 1);

        song = 8'd5;
        tick(1);
        chk("zRestA", int'(freqB), 5);
        chk("zRestACe", int'(ceB), 1);
        song = 8'd0;
        tick(1);
        chk("zRestB", int'(freqB), 0);
        chk("zRestBCe", int'(ceB), 0);
        chk("zRestBOwn", int'(ownB), 1);
        song = 8'd7;
        tick(1);
        chk("zRestC", int'(freqB), 7);
        chk("zRestCCe", int'(ceB), 1);
        tick(5);

        key = 8'd12;
        tick(6);
        chk("preRstFreq", int'(freqA), 12);
        #2 rst = 1'b1;
        #1;
        chk("asyncFreq", int'(freqA), 0);
        chk("asyncSh", int'(holdA), 0);
        chk("asyncOwn", int'(ownA), 0);
        chk("asyncCe", int'(ceA), 0);
        tick(2);
        key = 8'd0; valid = 1'b0;
        rst = 1'b0;
        tick(1);
        chk("postRstOwn", int'(ownA), 0);
        chk("postRstCe", int'(ceA), 0);
        chk("postRstFreq", int'(freqA), 0);
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule

// File: doc/note_arbiter.md
# note_arbiter

Shares the single buzzer note path between two requesters: live PS/2 key notes (decoded note codes) and the selected song's playback note stream. Sits between the decoder/song-selector outputs and the buzzer frequency decoder/counter. Key play preempts the song, the song is frozen while the player is playing, and a silent articulation gap is inserted before every new note so repeated notes are audibly separated.

## Interface
- GAP_CYCLES, 4: silent cycles inserted before each new note; 0 means the note starts next cycle
- HOLDOFF_CYCLES, 10: silent cycles after the last key release before the song resumes; minimum 1
- NOTE_W, 8: note code width; code 0 is rest
- iClk  in  1  clock (divided system clock)
- iReset  in  1  asynchronous, active-high reset
- iKey_Note  in  NOTE_W  decoded key note; 0 = no key held
- iSong_Note  in  NOTE_W  current note of selected song; 0 = rest
- iSong_Valid  in  1  a song is selected and enabled
- oFreq_Data  out  NOTE_W  note code to buzzer decoder
- oCountEnable  out  1  one-cycle pulse when a nonzero note starts sounding
- oSongHold  out  1  freeze song progress/timers
- oOwner  out  2  00 none, 01 song, 10 key

## Operation
- States: IDLE, GAP, SONG, KEY, HOLD. Registers: state, latched note, pending owner, down counter.
- IDLE: outputs silent. Key nonzero -> latch key, pending = key, GAP. Else iSong_Valid -> latch song note, pending = song, GAP. Key wins if both.
- GAP: oFreq_Data = 0. Counter loaded with GAP_CYCLES on entry; at 0 -> oFreq_Data = latched note, go to SONG/KEY per pending; oCountEnable pulses only if latched note is nonzero.
  - pending key, iKey_Note changes to another nonzero: re-latch, reload counter.
  - pending key, iKey_Note = 0: -> HOLD.
  - pending song, key nonzero: pending = key, latch key, reload counter.
  - pending song, iSong_Note changes: re-latch, counter not reloaded.
  - pending song, iSong_Valid = 0: -> IDLE.
- SONG: key nonzero -> latch key, pending = key, GAP. iSong_Valid = 0 -> IDLE. iSong_Note changes -> latch, GAP (a rest still passes through GAP, no pulse).
- KEY: iKey_Note equal to latched -> hold. Changed nonzero -> latch, GAP. Zero -> HOLD, counter = HOLDOFF_CYCLES.
- HOLD: oFreq_Data = 0. Key nonzero -> latch, pending = key, GAP. Counter reaches 0 -> iSong_Valid ? (latch song, GAP) : IDLE.
- oSongHold = 1 in KEY, HOLD, and GAP with pending key; else 0.
- oOwner: 10 in KEY, HOLD, GAP/key; 01 in SONG, GAP/song; 00 in IDLE.

## Timing
- All outputs registered; reset values: state IDLE, oFreq_Data 0, oCountEnable 0, oSongHold 0, oOwner 00, counter 0.
- Inputs sampled at rising edge N; resulting state/outputs valid after edge N, i.e. from cycle N+1.
- New key at edge N: oFreq_Data = 0 for cycles N+1..N+GAP_CYCLES, note and oCountEnable at N+GAP_CYCLES+1.
- Counter width clog2(max(GAP_CYCLES, HOLDOFF_CYCLES)+1); no wrap, saturates at 0.
- Reset asserted mid-note: all outputs return to reset values asynchronously; no pulse on deassertion.
- Key and song changes on the same edge: key handling only; the song change is resampled later.

## Structure
- Package note_pkg: NOTE_W, NOTE_REST = 0, owner encodings, state enum.
- Sub-module gap_timer: loadable down counter with load, load value and done (count == 0) outputs; shared by GAP and HOLD.

## Test plan
- Reset, iSong_Valid = 1, iSong_Note = 5 -> owner 01, oFreq_Data 0 for 4 cycles, then 5 with one oCountEnable pulse, oSongHold 0.
- Song playing 5, iKey_Note = 12 at edge N -> oSongHold = 1 and owner 10 from N+1, oFreq_Data 12 at N+5 with a pulse.
- Key 12 released -> oFreq_Data 0, oSongHold 1 for 10 cycles, then 4-cycle gap, then the song note resumes, oSongHold 0.
- Key pressed again 3 cycles into HOLD -> no song resumption; new key note after 4-cycle gap.
- GAP_CYCLES = 0, song note 5 -> 0 (rest) -> 7 -> oFreq_Data 5, 0, 7 on consecutive change cycles; pulses only for 5 and 7.
- Reset asserted while KEY sounds 12 -> oFreq_Data 0, oSongHold 0, oOwner 00 immediately, IDLE after release.
